// File: rtl/verdict_release_ctrl_pkg.sv
// Shared types for the verdict release controller: the Avalon-ST beat and the
// release state machine encoding.
package verdict_release_ctrl_pkg;

   localparam int AVLN_DATA_W  = 32;
   localparam int AVLN_EMPTY_W = 2;

   typedef struct packed {
      logic [AVLN_DATA_W-1:0]  data;
      logic                    sop;
      logic                    eop;
      logic [AVLN_EMPTY_W-1:0] empty;
      logic                    valid;
   } avln_st;

   typedef enum logic [1:0] {
      VR_WAIT    = 2'd0,
      VR_FORWARD = 2'd1,
      VR_DISCARD = 2'd2
   } vr_state_t;

   // A head word that is present but does not start a packet.
   function automatic logic head_is_orphan(input avln_st head, input logic head_empty);
      return ~head_empty & ~head.sop;
   endfunction

endpackage

// File: rtl/verdict_release_ctrl_verdict_queue.sv
// One-bit-wide synchronous show-ahead FIFO holding per-packet drop verdicts
// in arrival order. A pop in the same cycle frees a slot for a push when full.
module verdict_queue #(
   parameter int DEPTH = 16
) (
   input  logic sys_clk,
   input  logic reset_n,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int PTR_W = $clog2(DEPTH) + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                    (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[PTR_W-2:0]];

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (do_push) mem[wr_ptr[PTR_W-2:0]] <= din;
   end

endmodule

// File: rtl/verdict_release_ctrl.sv
// Releases packets from the show-ahead packet FIFO to the egress port once the
// classifier verdict for each packet is known; dropped packets are drained silently.
module verdict_release_ctrl
   import verdict_release_ctrl_pkg::*;
#(
   parameter int VQ_DEPTH = 16,
   parameter int CNT_W    = 32
) (
   input  logic             sys_clk,
   input  logic             reset_n,
   input  logic             verdict_valid,
   input  logic             verdict_drop,
   input  avln_st           fifo_q,
   input  logic             fifo_empty,
   output logic             fifo_rd,
   output avln_st           out,
   input  logic             out_ready,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             err_vq_ovf,
   output logic             err_orphan
);

   vr_state_t state;
   vr_state_t state_nxt;

   logic ld;
   logic vq_pop;
   logic vq_dout;
   logic vq_full;
   logic vq_empty;
   logic orphan;
   logic eop_pop;

   verdict_queue #(
      .DEPTH (VQ_DEPTH)
   ) u_vq (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .push    (verdict_valid),
      .din     (verdict_drop),
      .pop     (vq_pop),
      .dout    (vq_dout),
      .full    (vq_full),
      .empty   (vq_empty)
   );

   assign ld      = ~out.valid | out_ready;
   assign eop_pop = fifo_rd & fifo_q.eop;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) state <= VR_WAIT;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         VR_WAIT:    if (vq_pop) state_nxt = vq_dout ? VR_DISCARD : VR_FORWARD;
         VR_FORWARD: if (eop_pop) state_nxt = VR_WAIT;
         VR_DISCARD: if (eop_pop) state_nxt = VR_WAIT;
         default:    state_nxt = VR_WAIT;
      endcase
   end

   // The verdict is consumed in WAIT; the SOP word itself is popped in the next state.
   always_comb begin
      fifo_rd = 1'b0;
      vq_pop  = 1'b0;
      orphan  = 1'b0;
      case (state)
         VR_WAIT: begin
            if (head_is_orphan(fifo_q, fifo_empty)) begin
               fifo_rd = 1'b1;
               orphan  = 1'b1;
            end else if (!fifo_empty) begin
               vq_pop = ~vq_empty;
            end
         end
         VR_FORWARD: fifo_rd = ~fifo_empty & ld;
         VR_DISCARD: fifo_rd = ~fifo_empty;
         default:    fifo_rd = 1'b0;
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         out <= '0;
      end else if (ld) begin
         if (state == VR_FORWARD && fifo_rd) begin
            out       <= fifo_q;
            out.valid <= 1'b1;
         end else begin
            out.valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         pass_cnt   <= '0;
         drop_cnt   <= '0;
         err_vq_ovf <= 1'b0;
         err_orphan <= 1'b0;
      end else begin
         if (state == VR_FORWARD && eop_pop) pass_cnt <= pass_cnt + CNT_W'(1);
         if (state == VR_DISCARD && eop_pop) drop_cnt <= drop_cnt + CNT_W'(1);
         if (verdict_valid && vq_full && !vq_pop) err_vq_ovf <= 1'b1;
         if (orphan) err_orphan <= 1'b1;
      end
   end

endmodule
